tag_pool_alloc: RTL and testbench

- Allocates and retires transaction tags from a fixed pool of DEPTH tags shared among NUM_REQ requesters.
- Tracks tag occupancy in a busy bitmap and arbitrates allocation requests round-robin.
- Returns freed tags to the pool and flags tags held longer than a configurable timeout.
- Sits in front of the tag-tracking CAM in outstanding-transaction bookkeeping, acting as its allocation controller.

---
 rtl/tag_pool_pkg.sv | 14 +
 rtl/tag_pool_alloc_if.sv | 32 +++
 rtl/arbiter_round_robin.sv | 43 ++++
 rtl/tag_pool_alloc.sv | 126 ++++++++++++
 tb/tb_tag_pool_alloc.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/tag_pool_pkg.sv
// Shared types and sizing helpers for the tag pool allocator.
package tag_pool_pkg;

  typedef enum logic [1:0] {
    FREE_OK,
    FREE_NOT_BUSY,
    FREE_RANGE
  } free_cause_e;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/tag_pool_alloc_if.sv
// Request/grant and free bus between requesters and the tag pool allocator.
interface tag_pool_alloc_if #(
  parameter int unsigned N       = 4,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned NUM_REQ = 4
);
  import tag_pool_pkg::*;

  localparam int unsigned CW = cnt_width(DEPTH);

  logic [NUM_REQ-1:0] i_req;
  logic [NUM_REQ-1:0] o_gnt;
  logic [N-1:0]       o_gnt_tag;
  logic               i_free_valid;
  logic [N-1:0]       i_free_tag;
  logic               o_free_err;
  logic [CW-1:0]      o_count;
  logic               o_full;
  logic               o_empty;
  logic [DEPTH-1:0]   o_timeout;

  modport master (
    output i_req, i_free_valid, i_free_tag,
    input  o_gnt, o_gnt_tag, o_free_err, o_count, o_full, o_empty, o_timeout
  );

  modport slave (
    input  i_req, i_free_valid, i_free_tag,
    output o_gnt, o_gnt_tag, o_free_err, o_count, o_full, o_empty, o_timeout
  );

endinterface

// File: rtl/arbiter_round_robin.sv
// Round-robin arbiter: combinational one-hot pick, search starts after the last winner.
module arbiter_round_robin #(
  parameter int unsigned CLIENTS = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [CLIENTS-1:0] i_req,
  input  logic               i_advance,
  output logic [CLIENTS-1:0] o_gnt
);

  localparam int unsigned PW = (CLIENTS > 1) ? $clog2(CLIENTS) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] idx;
  logic [PW:0]   sum;

  always_comb begin
    o_gnt   = '0;
    win_idx = ptr_q;
    idx     = '0;
    sum     = '0;
    for (int unsigned k = 0; k < CLIENTS; k++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(CLIENTS)) sum = sum - (PW+1)'(CLIENTS);
      idx = sum[PW-1:0];
      if (o_gnt == '0 && i_req[idx]) begin
        o_gnt[idx] = 1'b1;
        win_idx    = idx;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else if (i_advance && o_gnt != '0) begin
      ptr_q <= (win_idx == PW'(CLIENTS - 1)) ? '0 : win_idx + 1'b1;
    end
  end

endmodule

// File: rtl/tag_pool_alloc.sv
// Tag pool allocator: busy bitmap, round-robin allocation, free checking and per-tag age timeout.
module tag_pool_alloc
  import tag_pool_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input logic             i_clk,
  input logic             i_rst_n,
  tag_pool_alloc_if.slave bus
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned AW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  if (DEPTH > (1 << N)) begin : g_depth_chk
    $error("tag_pool_alloc: DEPTH must not exceed 2**N");
  end

  logic [DEPTH-1:0]   busy_q;
  logic [AW-1:0]      age_q [DEPTH];
  logic [NUM_REQ-1:0] gnt_q;
  logic [N-1:0]       gnt_tag_q;
  logic               free_err_q;
  logic [CW-1:0]      count_q;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] arb_gnt;
  logic               full;
  logic               alloc_go;
  logic [N-1:0]       alloc_tag;
  logic [DEPTH-1:0]   alloc_mask;
  logic [DEPTH-1:0]   free_mask;
  logic               free_hit;
  free_cause_e        free_cause;

  assign full     = (count_q == CW'(DEPTH));
  // Mask this cycle's winner so a still-high request is not granted twice in a row.
  assign eligible = bus.i_req & ~gnt_q;
  assign alloc_go = (arb_gnt != '0) && !full;

  arbiter_round_robin #(.CLIENTS(NUM_REQ)) u_arb (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_req     (eligible),
    .i_advance (alloc_go),
    .o_gnt     (arb_gnt)
  );

  always_comb begin
    alloc_tag  = '0;
    alloc_mask = '0;
    for (int unsigned i = DEPTH; i > 0; i--) begin
      if (!busy_q[i-1]) alloc_tag = N'(i - 1);
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      alloc_mask[i] = alloc_go && (alloc_tag == N'(i));
    end
  end

  always_comb begin
    free_mask  = '0;
    free_cause = FREE_OK;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      free_mask[i] = (bus.i_free_tag == N'(i));
    end
    // Widened compare keeps DEPTH == 2**N from wrapping to zero.
    if ({1'b0, bus.i_free_tag} >= (N+1)'(DEPTH)) begin
      free_cause = FREE_RANGE;
    end else if ((busy_q & free_mask) == '0) begin
      free_cause = FREE_NOT_BUSY;
    end
    free_hit = bus.i_free_valid && (free_cause == FREE_OK);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q     <= '0;
      gnt_q      <= '0;
      gnt_tag_q  <= '0;
      free_err_q <= 1'b0;
      count_q    <= '0;
    end else begin
      busy_q     <= (busy_q & ~(free_hit ? free_mask : '0)) | alloc_mask;
      gnt_q      <= alloc_go ? arb_gnt : '0;
      free_err_q <= bus.i_free_valid && (free_cause != FREE_OK);
      if (alloc_go) gnt_tag_q <= alloc_tag;
      case ({alloc_go, free_hit})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (alloc_mask[i]) begin
          age_q[i] <= '0;
        end else if (busy_q[i] && age_q[i] != AW'(TIMEOUT)) begin
          age_q[i] <= age_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.o_timeout = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      bus.o_timeout[i] = (TIMEOUT != 0) && busy_q[i] && (age_q[i] == AW'(TIMEOUT));
    end
  end

  assign bus.o_gnt      = gnt_q;
  assign bus.o_gnt_tag  = gnt_tag_q;
  assign bus.o_free_err = free_err_q;
  assign bus.o_count    = count_q;
  assign bus.o_full     = full;
  assign bus.o_empty    = (count_q == '0);

endmodule

// File: tb/tb_tag_pool_alloc.sv
// Scoreboard bench for tag_pool_alloc: expected grants/errors queued by stimulus, popped by a monitor.
module tb_tag_pool_alloc;

  localparam int unsigned N       = 5;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned TIMEOUT = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tag_pool_alloc_if #(.N(N), .DEPTH(DEPTH), .NUM_REQ(NUM_REQ)) bus ();

  tag_pool_alloc #(.N(N), .DEPTH(DEPTH), .NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic [4:0] tag;
  } gnt_t;

  gnt_t        gq[$];
  int unsigned eq[$];
  int          n_vec = 0;
  int          n_err = 0;
  gnt_t        exp_g;
  int unsigned exp_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_gnt != '0) begin
        n_vec++;
        if (gq.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_grant: got gnt=%b tag=%0d expected no grant", bus.o_gnt, bus.o_gnt_tag);
        end else begin
          exp_g = gq.pop_front();
          if (bus.o_gnt !== exp_g.gnt || bus.o_gnt_tag !== exp_g.tag) begin
            n_err++;
            $display("FAIL grant: got gnt=%b tag=%0d expected gnt=%b tag=%0d",
                     bus.o_gnt, bus.o_gnt_tag, exp_g.gnt, exp_g.tag);
          end
        end
      end
      if (bus.o_free_err) begin
        n_vec++;
        if (eq.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_free_err: got 1 expected 0");
        end else begin
          exp_e = eq.pop_front();
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [3:0] mask);
    logic [3:0]  pending;
    int unsigned cyc;
    pending   = mask;
    cyc       = 0;
    bus.i_req = bus.i_req | mask;
    while (pending != '0 && cyc < 64) begin
      tick();
      pending   = pending & ~bus.o_gnt;
      bus.i_req = bus.i_req & ~bus.o_gnt;
      cyc++;
    end
    if (pending != '0) begin
      n_vec++;
      n_err++;
      $display("FAIL req_wait: got pending=%b expected 0000", pending);
      bus.i_req = bus.i_req & ~pending;
    end
  endtask

  task automatic free_tag(input logic [4:0] t);
    bus.i_free_valid = 1'b1;
    bus.i_free_tag   = t;
    tick();
    bus.i_free_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_req        = '0;
    bus.i_free_valid = 1'b0;
    bus.i_free_tag   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_empty",   bus.o_empty,    1);
    check("rst_full",    bus.o_full,     0);
    check("rst_count",   bus.o_count,    0);
    check("rst_gnt",     bus.o_gnt,      0);
    check("rst_timeout", bus.o_timeout,  0);
    check("rst_free_err", bus.o_free_err, 0);
    @(negedge clk) rst_n = 1'b1;
    tick(); tick();
    check("idle_empty", bus.o_empty, 1);
    check("idle_count", bus.o_count, 0);

    // Four requesters at once, each dropping in its grant cycle.
    gq.push_back('{gnt: 4'b0001, tag: 5'd0});
    gq.push_back('{gnt: 4'b0010, tag: 5'd1});
    gq.push_back('{gnt: 4'b0100, tag: 5'd2});
    gq.push_back('{gnt: 4'b1000, tag: 5'd3});
    request(4'b1111);
    check("rr_count", bus.o_count, 4);
    check("rr_empty", bus.o_empty, 0);

    // Fill the pool.
    for (int k = 0; k < 12; k++) begin
      gq.push_back('{gnt: 4'b0001, tag: 5'(4 + k)});
      request(4'b0001);
    end
    check("fill_count", bus.o_count, 16);
    check("fill_full",  bus.o_full,  1);

    bus.i_req = 4'b0100;
    repeat (4) tick();
    check("full_nogrant", bus.o_gnt,  0);
    check("full_hold",    bus.o_full, 1);

    gq.push_back('{gnt: 4'b0100, tag: 5'd9});
    bus.i_free_valid = 1'b1;
    bus.i_free_tag   = 5'd9;
    tick();
    bus.i_free_valid = 1'b0;
    check("free9_t1_gnt",   bus.o_gnt,   0);
    check("free9_t1_count", bus.o_count, 15);
    tick();
    check("free9_t2_gnt", bus.o_gnt,     4'b0100);
    check("free9_t2_tag", bus.o_gnt_tag, 9);
    bus.i_req = '0;
    check("free9_count", bus.o_count, 16);

    // Free errors: tag 5 twice (second not busy), then out-of-range tag 17.
    free_tag(5'd5);
    check("free5_count", bus.o_count, 15);
    eq.push_back(5);
    free_tag(5'd5);
    check("err_notbusy_pulse", bus.o_free_err, 1);
    check("err_notbusy_count", bus.o_count,    15);
    eq.push_back(17);
    free_tag(5'd17);
    check("err_range_pulse", bus.o_free_err, 1);
    check("err_range_count", bus.o_count,    15);
    tick();
    check("err_single_pulse", bus.o_free_err, 0);

    // Same-cycle allocation (tag 5) and valid free (tag 0).
    gq.push_back('{gnt: 4'b0010, tag: 5'd5});
    bus.i_req        = 4'b0010;
    bus.i_free_valid = 1'b1;
    bus.i_free_tag   = 5'd0;
    tick();
    bus.i_free_valid = 1'b0;
    bus.i_req        = '0;
    check("both_gnt",   bus.o_gnt,   4'b0010);
    check("both_count", bus.o_count, 15);
    check("old_tag1_timeout", bus.o_timeout[1], 1);
    check("free_tag0_timeout", bus.o_timeout[0], 0);

    // Timeout on a freshly allocated tag 0.
    gq.push_back('{gnt: 4'b0001, tag: 5'd0});
    request(4'b0001);
    check("to_age0", bus.o_timeout[0], 0);
    repeat (9) tick();
    check("to_age9", bus.o_timeout[0], 0);
    tick();
    check("to_age10", bus.o_timeout[0], 1);
    repeat (3) tick();
    check("to_sticky", bus.o_timeout[0], 1);
    free_tag(5'd0);
    check("to_cleared", bus.o_timeout[0], 0);

    // Reset mid-operation with 8 tags busy and a grant pulse live.
    rst_n = 1'b0;
    tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("rst2_count", bus.o_count, 0);
    for (int k = 0; k < 7; k++) begin
      gq.push_back('{gnt: 4'b0001, tag: 5'(k)});
      request(4'b0001);
    end
    bus.i_req = 4'b0010;
    tick();
    check("pre_rst_gnt",   bus.o_gnt,     4'b0010);
    check("pre_rst_tag",   bus.o_gnt_tag, 7);
    check("pre_rst_count", bus.o_count,   8);
    #1 rst_n = 1'b0;
    #1;
    bus.i_req = '0;
    check("mid_rst_gnt",     bus.o_gnt,     0);
    check("mid_rst_count",   bus.o_count,   0);
    check("mid_rst_empty",   bus.o_empty,   1);
    check("mid_rst_full",    bus.o_full,    0);
    check("mid_rst_timeout", bus.o_timeout, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    gq.push_back('{gnt: 4'b0001, tag: 5'd0});
    gq.push_back('{gnt: 4'b0010, tag: 5'd1});
    gq.push_back('{gnt: 4'b1000, tag: 5'd2});
    request(4'b1011);
    check("post_rst_count", bus.o_count, 3);

    repeat (2) tick();
    check("gnt_queue_drained", gq.size(), 0);
    check("err_queue_drained", eq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
